axi2apb_txn_arbiter: RTL and testbench

Sequences the AXI4-Lite-to-APB4 bridge request path. It watches the write-address, write-data and read-address FIFOs filled by the AXI4-Lite slave, and picks the next transaction with round-robin between writes and reads. It pops the chosen FIFO entries and presents one command at a time to the APB4 master. It holds off the next command until the APB side reports completion, so at most one APB transfer is outstanding.

---
 rtl/axi2apb_txn_arbiter.sv | 131 +++++++++++++
 tb/tb_axi2apb_txn_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2apb_txn_arbiter.sv
// Write/read round-robin sequencer between the AXI4-Lite request FIFOs and the APB4 master; one APB transfer in flight.
// Optional completion watchdog enabled by defining AXI2APB_ARB_WDOG_EN.
module axi2apb_txn_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [AW+2:0]     w_addr_prot,
  input  logic              w_addr_empty,
  output logic              w_addr_ren,
  input  logic [DW/8+DW-1:0] w_data_strb,
  input  logic              w_data_empty,
  output logic              w_data_ren,
  input  logic [AW+2:0]     r_addr_prot,
  input  logic              r_addr_empty,
  output logic              r_addr_ren,
  output logic              cmd_valid,
  output logic              cmd_write,
  output logic [AW-1:0]     cmd_addr,
  output logic [2:0]        cmd_prot,
  output logic [DW-1:0]     cmd_wdata,
  output logic [DW/8-1:0]   cmd_wstrb,
  input  logic              cmd_ready,
  input  logic              cmd_done,
  output logic              busy,
  output logic              cmd_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t state;
  logic   last_wr;
  logic   wr_elig, rd_elig, grant_wr, grant_rd, done_now, wd_hit;

  assign wr_elig  = !w_addr_empty && !w_data_empty;
  assign rd_elig  = !r_addr_empty;
  // Under contention the direction not taken last time wins.
  assign grant_wr = (state == IDLE) && wr_elig && (!rd_elig || !last_wr);
  assign grant_rd = (state == IDLE) && rd_elig && (!wr_elig || last_wr);

  assign w_addr_ren = grant_wr;
  assign w_data_ren = grant_wr;
  assign r_addr_ren = grant_rd;

  assign done_now = ((state == ISSUE) && cmd_ready && cmd_done) ||
                    ((state == WAIT) && cmd_done);

`ifdef AXI2APB_ARB_WDOG_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);

  logic [CW-1:0] wd_cnt;

  // Counter is zero in the first ISSUE cycle, so the abort pulse lands TIMEOUT_CYC cycles after entry.
  assign wd_hit = ((state == ISSUE) || (state == WAIT)) && !done_now &&
                  (wd_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wd_cnt      <= '0;
      cmd_timeout <= 1'b0;
    end else begin
      cmd_timeout <= wd_hit;
      if (grant_wr || grant_rd)                  wd_cnt <= '0;
      else if (state == ISSUE || state == WAIT)  wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign cmd_timeout = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      last_wr   <= 1'b0;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_prot  <= '0;
      cmd_wdata <= '0;
      cmd_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            cmd_valid <= 1'b1;
            last_wr   <= grant_wr;
            cmd_write <= grant_wr;
            cmd_addr  <= grant_wr ? w_addr_prot[AW-1:0]  : r_addr_prot[AW-1:0];
            cmd_prot  <= grant_wr ? w_addr_prot[AW+2:AW] : r_addr_prot[AW+2:AW];
            cmd_wdata <= grant_wr ? w_data_strb[DW-1:0] : '0;
            cmd_wstrb <= grant_wr ? w_data_strb[DW+DW/8-1:DW] : '0;
          end
        end
        ISSUE: begin
          if (wd_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (cmd_done) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wd_hit || cmd_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi2apb_txn_arbiter.sv
// Directed + randomized bench for axi2apb_txn_arbiter against a transaction-level queue model.
module tb_axi2apb_txn_arbiter;
  localparam int AW = 32, DW = 32, SW = DW / 8, TO = 16;

  logic ACLK, ARESETn;
  logic [AW+2:0] w_addr_prot, r_addr_prot;
  logic [SW+DW-1:0] w_data_strb;
  logic w_addr_empty, w_data_empty, r_addr_empty;
  logic w_addr_ren, w_data_ren, r_addr_ren;
  logic cmd_valid, cmd_write, cmd_ready, cmd_done, busy, cmd_timeout;
  logic [AW-1:0] cmd_addr;
  logic [2:0] cmd_prot;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;

  axi2apb_txn_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .w_addr_prot(w_addr_prot), .w_addr_empty(w_addr_empty), .w_addr_ren(w_addr_ren),
    .w_data_strb(w_data_strb), .w_data_empty(w_data_empty), .w_data_ren(w_data_ren),
    .r_addr_prot(r_addr_prot), .r_addr_empty(r_addr_empty), .r_addr_ren(r_addr_ren),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_prot(cmd_prot),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .busy(busy), .cmd_timeout(cmd_timeout)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // FIFO contents and model state: phase 0 idle, 1 command offered, 2 awaiting completion.
  logic [AW+2:0]    waq[$], raq[$];
  logic [SW+DW-1:0] wdq[$];
  bit   seen_dir[$];
  int   phase, icnt, wcnt, wd_n, ready_lat, done_lat, to_seen;
  bit   last_wr, to_pend, spur;
  logic e_wr;
  logic [AW-1:0] e_addr;
  logic [2:0] e_prot;
  logic [DW-1:0] e_wdata;
  logic [SW-1:0] e_wstrb;
  int total, bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    w_addr_empty = (waq.size() == 0);
    w_data_empty = (wdq.size() == 0);
    r_addr_empty = (raq.size() == 0);
    w_addr_prot  = (waq.size() != 0) ? waq[0] : '0;
    w_data_strb  = (wdq.size() != 0) ? wdq[0] : '0;
    r_addr_prot  = (raq.size() != 0) ? raq[0] : '0;
  endtask

  task automatic respond();
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    if (phase == 1) begin
      cmd_ready = (icnt >= ready_lat);
      cmd_done  = cmd_ready ? (done_lat == 0) : (spur && $urandom_range(0, 3) == 0);
      icnt++;
    end else if (phase == 2) begin
      wcnt++;
      cmd_done = (wcnt >= done_lat);
    end else begin
      cmd_done = spur && ($urandom_range(0, 1) == 0);
    end
  endtask

  task automatic push_w(input logic [AW-1:0] a, input logic [2:0] p, input logic [DW-1:0] d, input logic [SW-1:0] s);
    waq.push_back({p, a});
    wdq.push_back({s, d});
    drive_fifo();
  endtask

  task automatic push_r(input logic [AW-1:0] a, input logic [2:0] p);
    raq.push_back({p, a});
    drive_fifo();
  endtask

  task automatic tick();
    logic [AW+2:0] ha;
    logic [SW+DW-1:0] hd;
    bit g_wr, g_rd, we, re, comp, abort;
    @(negedge ACLK);
    chk("cmd_valid", cmd_valid, phase == 1);
    chk("busy", busy, phase != 0);
    if (phase != 0) begin
      chk("cmd_write", cmd_write, e_wr);
      chk("cmd_addr", cmd_addr, e_addr);
      chk("cmd_prot", cmd_prot, e_prot);
      chk("cmd_wdata", cmd_wdata, e_wdata);
      chk("cmd_wstrb", cmd_wstrb, e_wstrb);
    end
    if (phase == 1 && cmd_ready && cmd_valid) seen_dir.push_back(cmd_write);
    chk("cmd_timeout", cmd_timeout, to_pend);
    if (cmd_timeout) to_seen++;
    to_pend = 0;
    g_wr = 0; g_rd = 0;
    if (phase == 0) begin
      we = (waq.size() != 0) && (wdq.size() != 0);
      re = (raq.size() != 0);
      g_wr = we && (!re || !last_wr);
      g_rd = re && !g_wr;
    end
    chk("w_addr_ren", w_addr_ren, g_wr);
    chk("w_data_ren", w_data_ren, g_wr);
    chk("r_addr_ren", r_addr_ren, g_rd);
    if (g_wr || g_rd) begin
      ha = g_wr ? waq[0] : raq[0];
      hd = g_wr ? wdq[0] : '0;
      e_wr = g_wr; e_addr = ha[AW-1:0]; e_prot = ha[AW+2:AW];
      e_wdata = hd[DW-1:0]; e_wstrb = hd[SW+DW-1:DW];
      last_wr = g_wr; phase = 1; icnt = 0; wd_n = 0;
    end else if (phase != 0) begin
      comp  = (phase == 1 && cmd_ready && cmd_done) || (phase == 2 && cmd_done);
      abort = 0;
`ifdef AXI2APB_ARB_WDOG_EN
      abort = !comp && (wd_n == TO - 1);
`endif
      if (abort) begin phase = 0; to_pend = 1; end
      else if (comp) phase = 0;
      else if (phase == 1 && cmd_ready) begin phase = 2; wcnt = 0; end
      wd_n++;
    end
    @(posedge ACLK); #1;
    if (g_wr) begin void'(waq.pop_front()); void'(wdq.pop_front()); end
    if (g_rd) void'(raq.pop_front());
    drive_fifo();
    respond();
  endtask

  function automatic bit settled();
    return (phase == 0) && !((waq.size() != 0) && (wdq.size() != 0)) && (raq.size() == 0);
  endfunction

  task automatic drain(input int n);
    for (int i = 0; i < n && !settled(); i++) tick();
    chk("drain_bound", settled(), 1);
    tick();
  endtask

  initial begin
    total = 0; bad = 0; phase = 0; last_wr = 0; to_pend = 0; spur = 0; to_seen = 0;
    ready_lat = 0; done_lat = 0; icnt = 0; wcnt = 0; wd_n = 0;
    ARESETn = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
    drive_fifo();
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_write", cmd_write, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_wdata", {cmd_prot, cmd_wstrb, cmd_wdata}, 0);
    chk("rst_ren", {w_addr_ren, w_data_ren, r_addr_ren}, 0);
    chk("rst_timeout", cmd_timeout, 0);
    ARESETn = 1'b1;
    repeat (2) tick();

    // Single write with delayed ready and completion.
    ready_lat = 2; done_lat = 3;
    push_w(32'h1000, 3'b010, 32'hDEADBEEF, 4'hF);
    drain(20);

    // Address without data must not issue.
    waq.push_back({3'b001, 32'h0000_2000});
    drive_fifo();
    repeat (10) tick();
    wdq.push_back({4'h3, 32'h1234_5678});
    drive_fifo();
    drain(20);

    // Long ready stall on a read; entries pushed meanwhile must not pop.
    ready_lat = 20; done_lat = 1;
    push_r($urandom, 3'($urandom));
    tick();
    push_w($urandom, 3'($urandom), $urandom, 4'($urandom));
    push_r($urandom, 3'($urandom));
    drain(150);

    // Contention with immediate completion: expect W,R,W,R,W,R.
    ready_lat = 0; done_lat = 0; seen_dir.delete();
    for (int i = 0; i < 3; i++) begin
      push_w($urandom, 3'($urandom), $urandom, 4'($urandom));
      push_r($urandom, 3'($urandom));
    end
    drain(40);
    chk("rr_count", seen_dir.size(), 6);
    for (int i = 0; i < seen_dir.size(); i++) chk("rr_order", seen_dir[i], (i % 2) == 0);

    // Randomized traffic with spurious completions outside the handshake.
    spur = 1;
    for (int c = 0; c < 300; c++) begin
      ready_lat = $urandom_range(0, 3);
      done_lat  = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin waq.push_back({3'($urandom), 32'($urandom)}); drive_fifo(); end
      if ($urandom_range(0, 3) == 0) begin wdq.push_back({4'($urandom), 32'($urandom)}); drive_fifo(); end
      if ($urandom_range(0, 3) == 0) push_r($urandom, 3'($urandom));
      tick();
    end
    spur = 0; ready_lat = 0; done_lat = 2;
    drain(400);

    // Reset while waiting for completion.
    ready_lat = 0; done_lat = 50;
    push_w(32'hCAFE_0000 | 32'($urandom_range(0, 255)), 3'b111, 32'hA5A5_5A5A, 4'hC);
    repeat (4) tick();
    #2 ARESETn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_cmd", {cmd_write, cmd_prot, cmd_addr}, 0);
    chk("mid_rst_data", {cmd_wstrb, cmd_wdata}, 0);
    waq.delete(); wdq.delete(); raq.delete();
    phase = 0; last_wr = 0; to_pend = 0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    drive_fifo();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    done_lat = 1; seen_dir.delete();
    push_r($urandom, 3'($urandom));
    push_w($urandom, 3'($urandom), $urandom, 4'($urandom));
    drain(30);
    chk("rst_first_wr", (seen_dir.size() != 0) ? seen_dir[0] : 1'b0, 1);

`ifdef AXI2APB_ARB_WDOG_EN
    // Command accepted but never completed; the queued read must follow the abort.
    ready_lat = 0; done_lat = 1000; to_seen = 0;
    push_w($urandom, 3'($urandom), $urandom, 4'($urandom));
    tick();
    push_r($urandom, 3'($urandom));
    for (int i = 0; i < 40 && to_seen == 0; i++) tick();
    chk("wdog_pulse", to_seen, 1);
    done_lat = 2;
    drain(40);
    chk("wdog_once", to_seen, 1);
`else
    chk("no_timeout", to_seen, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
